// File: rtl/intf_cfg_writer.sv
// Writes the PARAM-selected intf status field values (p1..p5) into a register bank over valid/ready.
// Optional readback-and-compare of each field is enabled by defining INTF_CFG_WRITER_READBACK_EN.
module intf_cfg_writer #(
  parameter int PARAM   = 0,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [2:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [2:0]        rd_addr,
  input  logic              rd_resp_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        mismatch_cnt
);

  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [7:0]        STALL_MAX = 8'(TIMEOUT - 1);
  localparam logic [2:0]        LAST_IDX  = 3'd6;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, DONE} state_t;

  state_t            state, state_n;
  logic [2:0]        idx, idx_n;
  logic [7:0]        stall, stall_n;
  logic              done_n, err_n;
  logic [2:0]        mcnt, mcnt_n;
  logic [DATA_W-1:0] p3, p3_no, p4, p4_no, p5;
  logic [DATA_W-1:0] tbl_val;

  // Field table built with the same generate forms the interface uses
  if (PARAM == 1) begin : g_p3
    assign p3    = ONE;
    assign p3_no = '0;
  end else begin : g_p3_no
    assign p3    = '0;
    assign p3_no = ONE;
  end

  case (PARAM)
    1: begin : g_p4
      assign p4    = ONE;
      assign p4_no = '0;
    end
    default: begin : g_p4_no
      assign p4    = '0;
      assign p4_no = ONE;
    end
  endcase

  logic [DATA_W-1:0] iter_cnt [PARAM+2];
  assign iter_cnt[0] = '0;
  for (genvar g = 0; g <= PARAM; g++) begin : g_p5
    assign iter_cnt[g+1] = iter_cnt[g] + ONE;
  end
  assign p5 = iter_cnt[PARAM+1];

  always_comb begin
    tbl_val = '0;
    case (idx)
      3'd0:    tbl_val = ONE;
      3'd1:    tbl_val = ONE;
      3'd2:    tbl_val = p3;
      3'd3:    tbl_val = p3_no;
      3'd4:    tbl_val = p4;
      3'd5:    tbl_val = p4_no;
      3'd6:    tbl_val = p5;
      default: tbl_val = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    stall_n = stall;
    done_n  = done;
    err_n   = err;
    mcnt_n  = mcnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WRITE;
          idx_n   = '0;
          stall_n = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          mcnt_n  = '0;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          stall_n = '0;
`ifdef INTF_CFG_WRITER_READBACK_EN
          state_n = READ;
`else
          if (idx == LAST_IDX) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
`endif
        end else if (stall == STALL_MAX) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
          stall_n = '0;
        end else begin
          stall_n = stall + 8'd1;
        end
      end
`ifdef INTF_CFG_WRITER_READBACK_EN
      READ: state_n = RWAIT;
      RWAIT: begin
        if (rd_resp_valid) begin
          stall_n = '0;
          // A mismatch is flagged but the remaining fields are still written
          if (rd_data != tbl_val) begin
            err_n = 1'b1;
            if (mcnt != 3'd7) mcnt_n = mcnt + 3'd1;
          end
          if (idx == LAST_IDX) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = WRITE;
            idx_n   = idx + 3'd1;
          end
        end else if (stall == STALL_MAX) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
          stall_n = '0;
        end else begin
          stall_n = stall + 8'd1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      stall <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      mcnt  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      stall <= stall_n;
      done  <= done_n;
      err   <= err_n;
      mcnt  <= mcnt_n;
    end
  end

  assign wr_valid = (state == WRITE);
  assign wr_addr  = wr_valid ? idx : '0;
  assign wr_data  = wr_valid ? tbl_val : '0;
  assign busy     = (state == WRITE) || (state == READ) || (state == RWAIT);

`ifdef INTF_CFG_WRITER_READBACK_EN
  assign rd_valid     = (state == READ);
  assign rd_addr      = rd_valid ? idx : '0;
  assign mismatch_cnt = mcnt;
`else
  logic unused_rd;
  assign unused_rd    = ^{rd_resp_valid, rd_data, mcnt};
  assign rd_valid     = 1'b0;
  assign rd_addr      = '0;
  assign mismatch_cnt = '0;
`endif

endmodule
